// File: rtl/hci_package.sv
// hci_package
//   Shared interconnect definitions: default widths for the bank starvation
//   controller and the interconnect control struct whose invert_prio and
//   low_prio_max_stall fields feed invert_prio_i / max_stall_i at integration.
`timescale 1ns/1ps
package hci_package;

  localparam int unsigned HCI_STALL_W = 8;
  localparam int unsigned HCI_STAT_W  = 32;

  typedef struct packed {
    logic [1:0]             arb_policy;
    logic                   invert_prio;
    logic [HCI_STALL_W-1:0] low_prio_max_stall;
  } hci_interconnect_ctrl_t;

endpackage

// File: rtl/hci_bank_starvation_ctrl_if.sv
// hci_bank_starvation_ctrl_if
//   Per-bank request/grant bundle between the two initiator classes, the
//   memory and the starvation controller.
//   master : drives req_high_i, req_low_i, gnt_mem_i; observes the rest
//   slave  : the controller; produces mem_req_o, sel_low_o, gnt_high_o, gnt_low_o
`timescale 1ns/1ps
interface hci_bank_starvation_ctrl_if #(
  parameter int unsigned N_MEM = 16
);
  logic [N_MEM-1:0] req_high_i;
  logic [N_MEM-1:0] req_low_i;
  logic [N_MEM-1:0] gnt_mem_i;
  logic [N_MEM-1:0] mem_req_o;
  logic [N_MEM-1:0] sel_low_o;
  logic [N_MEM-1:0] gnt_high_o;
  logic [N_MEM-1:0] gnt_low_o;

  modport master (
    output req_high_i, req_low_i, gnt_mem_i,
    input  mem_req_o, sel_low_o, gnt_high_o, gnt_low_o
  );

  modport slave (
    input  req_high_i, req_low_i, gnt_mem_i,
    output mem_req_o, sel_low_o, gnt_high_o, gnt_low_o
  );
endinterface

// File: rtl/hci_bank_starvation_cell.sv
// hci_bank_starvation_cell
//   One bank: combinational high/low arbitration plus the stall counter that
//   temporarily flips priority toward the default loser.
//   Ports: clk_i, rst_ni, flush_i (zero the counter), invert_prio_i,
//          max_stall_i, req_high_i, req_low_i, gnt_mem_i ->
//          mem_req_o, sel_low_o, gnt_high_o, gnt_low_o
`timescale 1ns/1ps
module hci_bank_starvation_cell
  import hci_package::*;
#(
  parameter int unsigned STALL_W = HCI_STALL_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               invert_prio_i,
  input  logic [STALL_W-1:0] max_stall_i,
  input  logic               req_high_i,
  input  logic               req_low_i,
  input  logic               gnt_mem_i,
  output logic               mem_req_o,
  output logic               sel_low_o,
  output logic               gnt_high_o,
  output logic               gnt_low_o
);

  logic [STALL_W-1:0] r_cnt;
  logic [STALL_W-1:0] w_cnt_next;
  logic               w_starve;
  logic               w_prio_low;
  logic               w_win_low;
  logic               w_win_high;
  logic               w_loser_req;
  logic               w_loser_gnt;

  // A max_stall of zero turns protection off entirely.
  assign w_starve   = (max_stall_i != '0) && (r_cnt >= max_stall_i);
  assign w_prio_low = invert_prio_i ^ w_starve;

  assign w_win_low  = req_low_i && (!req_high_i || w_prio_low);
  assign w_win_high = req_high_i && !w_win_low;

  assign mem_req_o  = req_high_i | req_low_i;
  assign sel_low_o  = w_win_low;
  assign gnt_high_o = w_win_high && gnt_mem_i;
  assign gnt_low_o  = w_win_low && gnt_mem_i;

  // The counter tracks the default loser only; a memory stall counts too.
  assign w_loser_req = invert_prio_i ? req_high_i : req_low_i;
  assign w_loser_gnt = invert_prio_i ? gnt_high_o : gnt_low_o;

  always_comb begin
    w_cnt_next = '0;
    if (flush_i) begin
      w_cnt_next = '0;
    end else if (w_loser_req && !w_loser_gnt) begin
      w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + STALL_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

endmodule

// File: rtl/hci_bank_starvation_ctrl.sv
// hci_bank_starvation_ctrl
//   Per-bank arbitration between the log-interconnect ("high") and HWPE
//   ("low") classes with per-bank starvation protection.
//   Ports: clk_i, rst_ni, clear_i, invert_prio_i, max_stall_i,
//          bus_if (slave modport: per-bank requests, memory grants, outputs),
//          stall_high_o / stall_low_o (cumulative stall bank-cycles).
//   Optional feature macro: HCI_BANK_STARVATION_STATS_EN enables the two
//   saturating statistics counters; without it the outputs are tied to 0.
`timescale 1ns/1ps
module hci_bank_starvation_ctrl
  import hci_package::*;
#(
  parameter int unsigned N_MEM   = 16,
  parameter int unsigned STALL_W = HCI_STALL_W,
  parameter int unsigned STAT_W  = HCI_STAT_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      invert_prio_i,
  input  logic [STALL_W-1:0]        max_stall_i,
  hci_bank_starvation_ctrl_if.slave bus_if,
  output logic [STAT_W-1:0]         stall_high_o,
  output logic [STAT_W-1:0]         stall_low_o
);

  logic             r_invert_prio;
  logic             w_flush;
  logic [N_MEM-1:0] w_gnt_high;
  logic [N_MEM-1:0] w_gnt_low;

  // A priority flip invalidates every count: they measured the other class.
  assign w_flush = clear_i | (invert_prio_i ^ r_invert_prio);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_invert_prio <= 1'b0;
    end else if (clear_i) begin
      r_invert_prio <= 1'b0;
    end else begin
      r_invert_prio <= invert_prio_i;
    end
  end

  for (genvar b = 0; b < N_MEM; b++) begin : g_bank
    hci_bank_starvation_cell #(
      .STALL_W (STALL_W)
    ) u_cell (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .flush_i       (w_flush),
      .invert_prio_i (invert_prio_i),
      .max_stall_i   (max_stall_i),
      .req_high_i    (bus_if.req_high_i[b]),
      .req_low_i     (bus_if.req_low_i[b]),
      .gnt_mem_i     (bus_if.gnt_mem_i[b]),
      .mem_req_o     (bus_if.mem_req_o[b]),
      .sel_low_o     (bus_if.sel_low_o[b]),
      .gnt_high_o    (w_gnt_high[b]),
      .gnt_low_o     (w_gnt_low[b])
    );
  end

  assign bus_if.gnt_high_o = w_gnt_high;
  assign bus_if.gnt_low_o  = w_gnt_low;

`ifdef HCI_BANK_STARVATION_STATS_EN
  logic [STAT_W-1:0] r_stall_high;
  logic [STAT_W-1:0] r_stall_low;
  logic [STAT_W-1:0] w_pop_high;
  logic [STAT_W-1:0] w_pop_low;
  logic [STAT_W:0]   w_sum_high;
  logic [STAT_W:0]   w_sum_low;

  always_comb begin
    w_pop_high = '0;
    w_pop_low  = '0;
    for (int b = 0; b < N_MEM; b++) begin
      w_pop_high = w_pop_high + STAT_W'(bus_if.req_high_i[b] & ~w_gnt_high[b]);
      w_pop_low  = w_pop_low  + STAT_W'(bus_if.req_low_i[b]  & ~w_gnt_low[b]);
    end
  end

  // One extra bit catches the carry so the counters stick at all-ones.
  assign w_sum_high = {1'b0, r_stall_high} + {1'b0, w_pop_high};
  assign w_sum_low  = {1'b0, r_stall_low}  + {1'b0, w_pop_low};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_high <= '0;
      r_stall_low  <= '0;
    end else if (clear_i) begin
      r_stall_high <= '0;
      r_stall_low  <= '0;
    end else begin
      r_stall_high <= w_sum_high[STAT_W] ? '1 : w_sum_high[STAT_W-1:0];
      r_stall_low  <= w_sum_low[STAT_W]  ? '1 : w_sum_low[STAT_W-1:0];
    end
  end

  assign stall_high_o = r_stall_high;
  assign stall_low_o  = r_stall_low;
`else
  assign stall_high_o = '0;
  assign stall_low_o  = '0;
`endif

endmodule

// File: tb/tb_hci_bank_starvation_ctrl.sv
`timescale 1ns/1ps
module tb_hci_bank_starvation_ctrl;

  localparam int unsigned N_MEM   = 16;
  localparam int unsigned STALL_W = 8;
  localparam int unsigned STAT_W  = 32;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               clear_i;
  logic               invert_prio_i;
  logic [STALL_W-1:0] max_stall_i;
  logic [STAT_W-1:0]  stall_high_o;
  logic [STAT_W-1:0]  stall_low_o;

  int n_pass  = 0;
  int n_total = 0;

  hci_bank_starvation_ctrl_if #(.N_MEM(N_MEM)) bus_if ();

  hci_bank_starvation_ctrl #(
    .N_MEM   (N_MEM),
    .STALL_W (STALL_W),
    .STAT_W  (STAT_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .invert_prio_i (invert_prio_i),
    .max_stall_i   (max_stall_i),
    .bus_if        (bus_if.slave),
    .stall_high_o  (stall_high_o),
    .stall_low_o   (stall_low_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic idle_reqs();
    bus_if.req_high_i = '0;
    bus_if.req_low_i  = '0;
  endtask

  task automatic test_reset();
    rst_ni        = 1'b0;
    clear_i       = 1'b0;
    invert_prio_i = 1'b0;
    max_stall_i   = 8'd1;
    bus_if.gnt_mem_i = '1;
    for (int c = 0; c < 4; c++) begin
      bus_if.req_high_i = 16'($urandom) | 16'h0001;
      bus_if.req_low_i  = 16'($urandom) | 16'h0001;
      tick();
    end
    sample();
    n_total++;
    if (dut.g_bank[0].u_cell.r_cnt !== 8'd0)
      $display("FAIL reset_hold_cnt0 got=%0d exp=0", dut.g_bank[0].u_cell.r_cnt);
    else n_pass++;
    tick();
    idle_reqs();
    max_stall_i = 8'd0;
    rst_ni = 1'b1;
    sample();
    n_total++;
    if ({bus_if.mem_req_o, bus_if.sel_low_o, bus_if.gnt_high_o, bus_if.gnt_low_o} !== 64'd0)
      $display("FAIL reset_outputs got=%h exp=0",
               {bus_if.mem_req_o, bus_if.sel_low_o, bus_if.gnt_high_o, bus_if.gnt_low_o});
    else n_pass++;
    n_total++;
    if ({stall_high_o, stall_low_o} !== 64'd0)
      $display("FAIL reset_stats got=%h exp=0", {stall_high_o, stall_low_o});
    else n_pass++;
    n_total++;
    if ({dut.g_bank[0].u_cell.r_cnt, dut.g_bank[2].u_cell.r_cnt,
         dut.g_bank[5].u_cell.r_cnt, dut.r_invert_prio} !== 25'd0)
      $display("FAIL reset_counters got=%h exp=0",
               {dut.g_bank[0].u_cell.r_cnt, dut.g_bank[2].u_cell.r_cnt,
                dut.g_bank[5].u_cell.r_cnt, dut.r_invert_prio});
    else n_pass++;
    tick();
  endtask

  // invert=0, max=3: low granted on cycles 3, 7, 11.
  task automatic test_contention();
    logic exp_low;
    invert_prio_i = 1'b0;
    max_stall_i   = 8'd3;
    bus_if.gnt_mem_i = '1;
    idle_reqs();
    tick();
    bus_if.req_high_i[0] = 1'b1;
    bus_if.req_low_i[0]  = 1'b1;
    for (int c = 0; c < 12; c++) begin
      sample();
      exp_low = ((c % 4) == 3);
      n_total++;
      if (bus_if.gnt_low_o[0] !== exp_low)
        $display("FAIL contention_gnt_low c=%0d got=%b exp=%b", c, bus_if.gnt_low_o[0], exp_low);
      else n_pass++;
      n_total++;
      if (bus_if.gnt_high_o[0] !== !exp_low)
        $display("FAIL contention_gnt_high c=%0d got=%b exp=%b", c, bus_if.gnt_high_o[0], !exp_low);
      else n_pass++;
      tick();
    end
    idle_reqs();
    tick();
  endtask

  // max=0: low never wins and the counter sticks at 255.
  task automatic test_no_starve();
    int low_grants;
    low_grants  = 0;
    max_stall_i = 8'd0;
    bus_if.req_high_i[0] = 1'b1;
    bus_if.req_low_i[0]  = 1'b1;
    for (int c = 0; c < 300; c++) begin
      sample();
      if (bus_if.gnt_low_o[0]) low_grants++;
      if (c == 254 || c == 255 || c == 299) begin
        n_total++;
        if (dut.g_bank[0].u_cell.r_cnt !== ((c > 255) ? 8'd255 : 8'(c)))
          $display("FAIL nostarve_cnt c=%0d got=%0d exp=%0d", c,
                   dut.g_bank[0].u_cell.r_cnt, (c > 255) ? 255 : c);
        else n_pass++;
      end
      tick();
    end
    n_total++;
    if (low_grants !== 0)
      $display("FAIL nostarve_low_grants got=%0d exp=0", low_grants);
    else n_pass++;
    // Lowering max below the held count starves immediately.
    max_stall_i = 8'd10;
    sample();
    n_total++;
    if (bus_if.gnt_low_o[0] !== 1'b1)
      $display("FAIL max_change_immediate got=%b exp=1", bus_if.gnt_low_o[0]);
    else n_pass++;
    tick();
    sample();
    n_total++;
    if ({bus_if.gnt_high_o[0], dut.g_bank[0].u_cell.r_cnt} !== {1'b1, 8'd0})
      $display("FAIL max_change_after got=%b/%0d exp=1/0",
               bus_if.gnt_high_o[0], dut.g_bank[0].u_cell.r_cnt);
    else n_pass++;
    idle_reqs();
    max_stall_i = 8'd0;
    tick();
  endtask

  // invert=1, max=2 on bank 5: high granted on cycles 2 and 5. At cycle 8
  // invert drops to 0 while cnt=2 (>= max), so the stale count still flips
  // priority: low wins that cycle. From cycle 9 counts restart with low as
  // loser, so low is granted on 11 and 14.
  task automatic test_invert_flip();
    logic exp_low;
    invert_prio_i = 1'b1;
    max_stall_i   = 8'd2;
    idle_reqs();
    tick();
    tick();
    bus_if.req_high_i[5] = 1'b1;
    bus_if.req_low_i[5]  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      sample();
      exp_low = ((c % 3) != 2);
      n_total++;
      if ({bus_if.gnt_low_o[5], bus_if.gnt_high_o[5]} !== {exp_low, !exp_low})
        $display("FAIL invert_phase_a c=%0d got=%b%b exp=%b%b", c,
                 bus_if.gnt_low_o[5], bus_if.gnt_high_o[5], exp_low, !exp_low);
      else n_pass++;
      tick();
    end
    invert_prio_i = 1'b0;
    sample();
    n_total++;
    if ({bus_if.gnt_low_o[5], dut.g_bank[5].u_cell.r_cnt} !== {1'b1, 8'd2})
      $display("FAIL invert_flip_cycle got=%b/%0d exp=1/2",
               bus_if.gnt_low_o[5], dut.g_bank[5].u_cell.r_cnt);
    else n_pass++;
    tick();
    sample();
    n_total++;
    if (dut.g_bank[5].u_cell.r_cnt !== 8'd0)
      $display("FAIL invert_flush_cnt got=%0d exp=0", dut.g_bank[5].u_cell.r_cnt);
    else n_pass++;
    for (int c = 9; c < 15; c++) begin
      if (c != 9) sample();
      exp_low = (((c - 9) % 3) == 2);
      n_total++;
      if ({bus_if.gnt_low_o[5], bus_if.gnt_high_o[5]} !== {exp_low, !exp_low})
        $display("FAIL invert_phase_b c=%0d got=%b%b exp=%b%b", c,
                 bus_if.gnt_low_o[5], bus_if.gnt_high_o[5], exp_low, !exp_low);
      else n_pass++;
      tick();
    end
    idle_reqs();
    tick();
  endtask

  task automatic test_backpressure();
    invert_prio_i = 1'b0;
    max_stall_i   = 8'd3;
    idle_reqs();
    bus_if.gnt_mem_i[2] = 1'b0;
    bus_if.req_low_i[2] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sample();
      n_total++;
      if ({bus_if.mem_req_o[2], bus_if.sel_low_o[2], bus_if.gnt_low_o[2], bus_if.gnt_high_o[2]} !== 4'b1100)
        $display("FAIL backpressure c=%0d got=%b exp=1100", c,
                 {bus_if.mem_req_o[2], bus_if.sel_low_o[2], bus_if.gnt_low_o[2], bus_if.gnt_high_o[2]});
      else n_pass++;
      tick();
    end
    bus_if.req_high_i[2] = 1'b1;
    bus_if.gnt_mem_i[2]  = 1'b1;
    sample();
    n_total++;
    if ({dut.g_bank[2].u_cell.r_cnt, bus_if.gnt_low_o[2], bus_if.gnt_high_o[2]} !== {8'd4, 2'b10})
      $display("FAIL backpressure_release got=%0d/%b%b exp=4/10",
               dut.g_bank[2].u_cell.r_cnt, bus_if.gnt_low_o[2], bus_if.gnt_high_o[2]);
    else n_pass++;
    tick();
    sample();
    n_total++;
    if ({dut.g_bank[2].u_cell.r_cnt, bus_if.gnt_high_o[2]} !== {8'd0, 1'b1})
      $display("FAIL backpressure_after got=%0d/%b exp=0/1",
               dut.g_bank[2].u_cell.r_cnt, bus_if.gnt_high_o[2]);
    else n_pass++;
    idle_reqs();
    tick();
  endtask

  task automatic test_clear();
    max_stall_i = 8'd0;
    bus_if.req_high_i[0] = 1'b1;
    bus_if.req_low_i[0]  = 1'b1;
    repeat (5) tick();
    sample();
    n_total++;
    if (dut.g_bank[0].u_cell.r_cnt !== 8'd5)
      $display("FAIL clear_precount got=%0d exp=5", dut.g_bank[0].u_cell.r_cnt);
    else n_pass++;
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    sample();
    n_total++;
    if (dut.g_bank[0].u_cell.r_cnt !== 8'd0)
      $display("FAIL clear_cnt got=%0d exp=0", dut.g_bank[0].u_cell.r_cnt);
    else n_pass++;
    idle_reqs();
    tick();
  endtask

  task automatic test_stats();
    logic [STAT_W-1:0] exp_low;
`ifdef HCI_BANK_STARVATION_STATS_EN
    exp_low = 32'd40;
`else
    exp_low = 32'd0;
`endif
    invert_prio_i = 1'b0;
    max_stall_i   = 8'd0;
    bus_if.gnt_mem_i = '1;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    bus_if.req_high_i = 16'h000F;
    bus_if.req_low_i  = 16'h000F;
    repeat (10) tick();
    idle_reqs();
    sample();
    n_total++;
    if (stall_low_o !== exp_low)
      $display("FAIL stats_low got=%0d exp=%0d", stall_low_o, exp_low);
    else n_pass++;
    n_total++;
    if (stall_high_o !== 32'd0)
      $display("FAIL stats_high got=%0d exp=0", stall_high_o);
    else n_pass++;
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    sample();
    n_total++;
    if ({stall_high_o, stall_low_o} !== 64'd0)
      $display("FAIL stats_clear got=%h exp=0", {stall_high_o, stall_low_o});
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_no_starve();
    test_invert_flip();
    test_backpressure();
    test_clear();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
